md_unit: RTL
============

// Module: md_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit; consumes the ALU A operand and the
//  selected B operand (rs2 or immediate path) for M-extension instructions.
//  Sits beside the single-cycle ALU in EX, stalls the pipeline through a
//  valid/ready handshake, and returns the result plus rd tag to writeback.
// PARAMETERS
//  w        32   datapath width (operands, result)
//  RW       5    destination register tag width
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    synchronous active-low reset
//  flush      in   1    abort in-flight op (branch mispredict/trap)
//  in_valid   in   1    operands + op valid
//  in_ready   out  1    unit can accept (state==IDLE)
//  op         in   3    funct3: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//  a          in   w    operand A (rs1)
//  b          in   w    operand B (from operand-B select)
//  rd_in      in   RW   destination tag
//  out_valid  out  1    result valid; held until out_ready
//  out_ready  in   1    writeback accepts result
//  result     out  w    result word
//  rd_out     out  RW   tag of result
//  busy       out  1    state!=IDLE (pipeline stall)
// BEHAVIOUR
//  - Clock and reset: one clock clk; reset rst_n is synchronous, active-low.
//  - Reset (rst_n=0 at posedge): state=IDLE, out_valid=0, result=0, rd_out=0,
//    busy=0, in_ready=1 after release; any in-flight op is discarded.
//  - FSM IDLE->CALC->DONE->IDLE. Accept on in_valid&&in_ready; latch op, rd,
//    |a|,|b| and sign flags (signed ops only; MULHSU: only a signed).
//  - CALC: exactly w iterations, one per cycle, 6-bit counter 0..w-1.
//    MUL*: shift-add into 2w product; DIV*/REM*: restoring divide step
//    (md_divstep), quotient/remainder regs.
//  - Final sign fix in the CALC->DONE transition: product negated if sa^sb;
//    quotient negated if sa^sb; remainder takes sign of dividend.
//  - Result select: MUL low w; MULH/MULHSU/MULHU high w; DIV/DIVU quotient;
//    REM/REMU remainder.
//  - Latency: accept edge + w CALC cycles -> out_valid asserted w+1 cycles
//    after the accept edge; DONE holds result/rd_out stable until out_ready.
//  - DONE->IDLE on out_ready; no new accept in the same cycle (in_ready=0 in DONE).
//  - Special cases bypass CALC (IDLE->DONE, out_valid next cycle):
//    b==0: DIV/DIVU q=all-ones, REM/REMU r=a.
//    DIV/REM with a=-2^(w-1), b=-1: q=-2^(w-1), r=0.
//  - flush: any state -> IDLE next cycle, out_valid=0; flush dominates
//    in_valid and out_ready in the same cycle.
//  - a/b/op changes after acceptance are ignored.
// CONFIGURATION
//  MD_DIVIDE_EN defined: all eight ops supported as above.
//  MD_DIVIDE_EN undefined: divider datapath and md_divstep removed. DIV*/REM*
//  are accepted and complete IDLE->DONE with result=0; MUL* unchanged.
// STRUCTURE
//  md_pkg: md_op_e (funct3 encodings), md_state_e {IDLE,CALC,DONE},
//  MD_ITER=w constant.
//  Sub-module md_divstep (combinational): one restoring step
//  {rem,quo} -> {rem',quo'}. Instantiated under MD_DIVIDE_EN only.
// TESTING
//  1 MUL a=7, b=-3 -> result=0xFFFFFFEB, out_valid at accept+33 cycles.
//  2 MULH a=0x80000000, b=0x80000000 -> 0x40000000;
//    MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
//  3 DIV a=-7, b=2 -> 0xFFFFFFFD; REM a=-7, b=2 -> 0xFFFFFFFF;
//    DIVU a=100, b=7 -> 14.
//  4 DIV a=5, b=0 -> 0xFFFFFFFF and REMU a=5, b=0 -> 5, each 1 cycle after accept;
//    DIV a=0x80000000, b=-1 -> 0x80000000.
//  5 Hold out_ready=0 for 10 cycles in DONE -> result/rd_out stable, in_ready=0;
//    then out_ready=1 -> IDLE next cycle.
//  6 flush at CALC iteration 12, and rst_n=0 mid-CALC -> IDLE next cycle, no
//    out_valid; next op MULHU 3*5 -> 0 completes normally.

Source files
------------

// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Shared types and constants for the RV32M multiply/divide
//                unit: funct3 operation encodings, FSM states, iteration count.
//  Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    // Number of shift-add / restoring-divide iterations (equals datapath width)
    localparam int MD_ITER = 32;

    // funct3 encodings of the M-extension operations
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_e;

endpackage
`default_nettype wire

// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit_if
//  Description : Issue/result handshake bundle between EX and the
//                multiply/divide unit. master = pipeline side, slave = unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface md_unit_if #(
    parameter int W  = 32,
    parameter int RW = 5
) ();
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [RW-1:0] rd_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [RW-1:0] rd_out;
    logic          busy;

    modport master (
        output in_valid, op, a, b, rd_in, out_ready,
        input  in_ready, out_valid, result, rd_out, busy
    );

    modport slave (
        input  in_valid, op, a, b, rd_in, out_ready,
        output in_ready, out_valid, result, rd_out, busy
    );
endinterface
`default_nettype wire

// File: rtl/md_divstep.sv
`default_nettype none
// ============================================================================
//  Module      : md_divstep
//  Description : One combinational restoring-division step. The next dividend
//                bit is shifted from the top of the quotient register into the
//                partial remainder; the divisor is subtracted when it fits.
//                Only built when MD_DIVIDE_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifdef MD_DIVIDE_EN
module md_divstep #(
    parameter int W = 32
) (
    input  wire  [W-1:0] i_rem,
    input  wire  [W-1:0] i_quo,
    input  wire  [W-1:0] i_divisor,
    output logic [W-1:0] o_rem,
    output logic [W-1:0] o_quo
);
    logic [W:0] w_shifted;
    logic [W:0] w_diff;

    // Trial subtraction; bit W of the difference is the borrow (remainder < divisor)
    always_comb begin
        w_shifted = {i_rem, i_quo[W-1]};
        w_diff    = w_shifted - {1'b0, i_divisor};
        if (!w_diff[W]) begin
            o_rem = w_diff[W-1:0];
            o_quo = {i_quo[W-2:0], 1'b1};
        end else begin
            o_rem = w_shifted[W-1:0];
            o_quo = {i_quo[W-2:0], 1'b0};
        end
    end
endmodule
`endif
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit
//  Description : Iterative RV32M multiply/divide unit. Operands are captured
//                as magnitudes plus sign flags, processed one bit per cycle,
//                and sign-corrected on the last iteration. Build macro
//                MD_DIVIDE_EN enables the divider; without it DIV/REM ops
//                complete immediately with result 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_unit
    import md_pkg::*;
#(
    parameter int W  = MD_ITER,
    parameter int RW = 5
) (
    input wire       clk,
    input wire       rst_n,
    input wire       flush,
    md_unit_if.slave bus
);
    localparam logic [5:0] c_LAST_ITER = 6'(W - 1);

    md_state_e      r_state;
    md_op_e         r_op;
    logic [RW-1:0]  r_rd;
    logic [5:0]     r_cnt;
    // Shared accumulator: {product_hi, multiplier} for MUL*, {rem, quo} for DIV*
    logic [2*W-1:0] r_acc;
    // Multiplicand magnitude for MUL*, divisor magnitude for DIV*
    logic [W-1:0]   r_opb;
    logic           r_sa;
    logic           r_sb;
    logic [W-1:0]   r_result;

    md_op_e         w_op_in;
    logic           w_is_div;
    logic           w_sgn_a;
    logic           w_sgn_b;
    logic           w_sa;
    logic           w_sb;
    logic [W-1:0]   w_abs_a;
    logic [W-1:0]   w_abs_b;
    logic           w_special;
    logic [W-1:0]   w_spec_res;
    logic [W:0]     w_mul_sum;
    logic [2*W-1:0] w_acc_nxt;
    logic [2*W-1:0] w_prod_fix;
    logic [W-1:0]   w_final;

`ifdef MD_DIVIDE_EN
    logic           w_b_zero;
    logic           w_ovf;
    logic [W-1:0]   w_div_rem;
    logic [W-1:0]   w_div_quo;

    md_divstep #(.W(W)) u_divstep (
        .i_rem     (r_acc[2*W-1:W]),
        .i_quo     (r_acc[W-1:0]),
        .i_divisor (r_opb),
        .o_rem     (w_div_rem),
        .o_quo     (w_div_quo)
    );
`endif

    // Decode incoming op: operand signedness, magnitudes and the CALC-bypass cases
    always_comb begin
        w_op_in  = md_op_e'(bus.op);
        w_is_div = bus.op[2];
        w_sgn_a  = (w_op_in == OP_MULH) || (w_op_in == OP_MULHSU) ||
                   (w_op_in == OP_DIV)  || (w_op_in == OP_REM);
        w_sgn_b  = (w_op_in == OP_MULH) || (w_op_in == OP_DIV) || (w_op_in == OP_REM);
        w_sa     = w_sgn_a & bus.a[W-1];
        w_sb     = w_sgn_b & bus.b[W-1];
        w_abs_a  = w_sa ? (~bus.a + 1'b1) : bus.a;
        w_abs_b  = w_sb ? (~bus.b + 1'b1) : bus.b;
`ifdef MD_DIVIDE_EN
        w_b_zero  = (bus.b == '0);
        w_ovf     = ((w_op_in == OP_DIV) || (w_op_in == OP_REM)) &&
                    (bus.a == {1'b1, {(W-1){1'b0}}}) && (bus.b == '1);
        w_special = w_is_div && (w_b_zero || w_ovf);
        // op[1] distinguishes REM/REMU from DIV/DIVU
        if (w_b_zero)
            w_spec_res = bus.op[1] ? bus.a : '1;
        else
            w_spec_res = bus.op[1] ? '0 : {1'b1, {(W-1){1'b0}}};
`else
        w_special  = w_is_div;
        w_spec_res = '0;
`endif
    end

    // One iteration: shift-add multiply step, or restoring divide step
    always_comb begin
        w_mul_sum = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opb} : {(W+1){1'b0}});
        w_acc_nxt = {w_mul_sum, r_acc[W-1:1]};
`ifdef MD_DIVIDE_EN
        if (r_op[2])
            w_acc_nxt = {w_div_rem, w_div_quo};
`endif
    end

    // Sign correction and result select, applied to the final iteration's output
    always_comb begin
        w_prod_fix = (r_sa ^ r_sb) ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
        w_final    = '0;
        case (r_op)
            OP_MUL:                       w_final = w_prod_fix[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_fix[2*W-1:W];
`ifdef MD_DIVIDE_EN
            OP_DIV, OP_DIVU: w_final = (r_sa ^ r_sb) ? (~w_acc_nxt[W-1:0] + 1'b1)
                                                     : w_acc_nxt[W-1:0];
            OP_REM, OP_REMU: w_final = r_sa ? (~w_acc_nxt[2*W-1:W] + 1'b1)
                                            : w_acc_nxt[2*W-1:W];
`endif
            default:                      w_final = '0;
        endcase
    end

    // Control FSM: accept, iterate W cycles, hold result until writeback takes it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op     <= OP_MUL;
            r_rd     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_result <= '0;
        end else if (flush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_op  <= w_op_in;
                        r_rd  <= bus.rd_in;
                        r_sa  <= w_sa;
                        r_sb  <= w_sb;
                        r_cnt <= '0;
                        if (w_special) begin
                            r_result <= w_spec_res;
                            r_state  <= DONE;
                        end else begin
                            r_acc   <= w_is_div ? {{W{1'b0}}, w_abs_a} : {{W{1'b0}}, w_abs_b};
                            r_opb   <= w_is_div ? w_abs_b : w_abs_a;
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == c_LAST_ITER) begin
                        r_result <= w_final;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.result    = r_result;
    assign bus.rd_out    = r_rd;

endmodule
`default_nettype wire
